seven_segment_capture: RTL and testbench
========================================

// Module: seven_segment_capture
// PURPOSE
//  Reads back the four low active-low 7-segment display buses, waits for them to settle, and decodes them into a 16-bit hex word.
//  Hands the word to a downstream consumer over a valid/ready handshake, with a per-digit error mask.
//  Serves as the self-check monitor on the display output path of the bus-arbiter lab.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive unchanged cycles required before capture (legal range >=1)
//  DROP_W         8  width of the saturating dropped-word counter
// PORTS
//  clk_clk                  in   1   single clock, all logic on rising edge
//  reset_reset_n            in   1   asynchronous reset, active-low
//  seven_segment_display_0  in   7   digit 0 pattern, active-low {g,f,e,d,c,b,a}; digit 0 = LSB nibble
//  seven_segment_display_1  in   7   digit 1 pattern
//  seven_segment_display_2  in   7   digit 2 pattern
//  seven_segment_display_3  in   7   digit 3 pattern, MSB nibble
//  data_out                 out  16  decoded word {d3,d2,d1,d0}
//  error_mask               out  4   bit i = digit i pattern not in decode table
//  data_valid               out  1   data_out/error_mask offered
//  data_ready               in   1   consumer accepts when data_valid&&data_ready
//  overrun                  out  1   one-cycle pulse: an unaccepted word was overwritten
//  drop_count               out  DROP_W  saturating count of overwritten words
// BEHAVIOUR
//  Reset: all outputs 0; seg_q=7'h7F x4; cnt=0; state TRACK. Reset mid-offer discards the pending word.
//  Input register seg_q (28b) samples all digits every edge.
//  At any edge where input!=seg_q: cnt<=0. Otherwise cnt increments, saturating at STABLE_CYCLES.
//  Capture: the edge where input==seg_q and cnt==STABLE_CYCLES-1 (cnt goes to STABLE_CYCLES).
//   Latency: a pattern first sampled at edge E0 and held is captured at edge E0+STABLE_CYCLES; data_valid is high after that edge.
//   No recapture while the pattern stays unchanged. Any change, even a glitch, followed by a return re-arms a capture.
//  Decode table (hex:pattern): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10|18 A:08|20 b:03 C:46 d:21 E:06 F:0E.
//   Any other pattern, including blank 7F, decodes to 4'h0 and sets its error_mask bit.
//  FSM TRACK (valid=0) -> OFFER on capture.
//   OFFER -> TRACK on handshake with no capture that edge.
//   OFFER stays in OFFER on capture (new word loaded).
//  Capture in OFFER without handshake: data overwritten, overrun pulses, drop_count++ (saturating at all-ones).
//  Capture and handshake on the same edge: old word accepted, new word loaded, valid stays 1, no overrun.
//  data_out/error_mask are stable while valid&&!ready except at a capture edge.
// CONFIGURATION
//  Macro SEG_UPPER_CHECK_EN:
//   Defined: adds inputs seven_segment_display_4..7 (7b each) and output upper_nonblank (1b).
//    Upper digits join seg_q and the stability compare.
//    upper_nonblank is registered at capture, =1 if any upper digit !=7'h7F, and is held/overwritten like data_out.
//   Undefined: those ports and that logic are absent; stability covers digits 0..3 only.
// STRUCTURE
//  Package seven_segment_pkg: SEG_BLANK=7'h7F, 16-entry pattern constant array, alternate-pattern constants, state enum {S_TRACK,S_OFFER}.
//  Sub-module seg7_to_hex: combinational 7b -> {nibble[3:0], illegal}; instantiated once per digit.
//  Top: input register, stability counter, FSM, output registers, drop counter.
// TESTING
//  Hold d0..d3 = 24,30,40,79 from reset (STABLE_CYCLES=4) -> valid rises 4 edges after first sample; data_out=16'h1032, error_mask=0.
//  Same word with data_ready=0 for 20 cycles -> data stable and valid held; ready=1 -> valid falls next edge, no recapture.
//  d2 toggled 1 cycle to 7'h00 then back -> cnt restarts; word recaptured 4 edges after the restore.
//  d1=7'h7F, d3=7'h55 -> data_out=16'h0002 (d0=24 gives 2), error_mask=4'b1010.
//  Valid pending, ready=0, new stable word captured -> overrun 1 cycle, drop_count=1, newest data shown.
//   Repeat with ready=1 on the capture edge -> no overrun.
//  Assert reset_reset_n=0 mid-OFFER -> outputs 0 immediately, without waiting for a clock edge.
//   SEG_UPPER_CHECK_EN defined, d5=7'h40 -> upper_nonblank=1 at capture.

Source files
------------

// File: rtl/seven_segment_capture_pkg.sv
// Shared definitions for the seven-segment readback monitor.
// Contents:
//   SEG_BLANK    - all-segments-off pattern (active-low, so every bit is 1)
//   SEG_PATTERN  - canonical active-low {g,f,e,d,c,b,a} pattern for hex 0..F
//   SEG_ALT_9/A  - accepted alternate renderings of 9 and A
//   NUM_DIGITS   - digits taking part in the stability compare
//   state_t      - handshake FSM states
// Configuration macro: SEG_UPPER_CHECK_EN (adds digits 4..7 to the compare).
package seven_segment_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index i holds the pattern for nibble value i.
  localparam logic [15:0][6:0] SEG_PATTERN = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [6:0] SEG_ALT_9 = 7'h18;
  localparam logic [6:0] SEG_ALT_A = 7'h20;

`ifdef SEG_UPPER_CHECK_EN
  localparam int NUM_DIGITS = 8;
`else
  localparam int NUM_DIGITS = 4;
`endif

  typedef enum logic {
    S_TRACK = 1'b0,
    S_OFFER = 1'b1
  } state_t;

endpackage

// File: rtl/seven_segment_capture_if.sv
// Downstream word interface of the seven-segment monitor.
// Handshake: the producer raises data_valid and holds data_out/error_mask
// (and upper_nonblank when present) until a rising edge with
// data_valid && data_ready, which is the transfer; the only exception is a
// newer capture, which replaces the offered word in place.
// Signals:
//   data_out[15:0]     decoded word {d3,d2,d1,d0}
//   error_mask[3:0]    bit i set when digit i pattern was not decodable
//   data_valid         word offered
//   data_ready         consumer accepts
//   overrun            one-cycle pulse: an unaccepted word was overwritten
//   drop_count         saturating count of overwritten words
//   upper_nonblank     (SEG_UPPER_CHECK_EN only) any digit 4..7 not blank
// Configuration macro: SEG_UPPER_CHECK_EN.
interface seven_segment_capture_if #(
  parameter int DROP_W = 8
) ();
  logic [15:0]       data_out;
  logic [3:0]        error_mask;
  logic              data_valid;
  logic              data_ready;
  logic              overrun;
  logic [DROP_W-1:0] drop_count;
`ifdef SEG_UPPER_CHECK_EN
  logic              upper_nonblank;
`endif

  modport master (
    output data_out, error_mask, data_valid, overrun, drop_count,
`ifdef SEG_UPPER_CHECK_EN
    output upper_nonblank,
`endif
    input  data_ready
  );

  modport slave (
    input  data_out, error_mask, data_valid, overrun, drop_count,
`ifdef SEG_UPPER_CHECK_EN
    input  upper_nonblank,
`endif
    output data_ready
  );
endinterface

// File: rtl/seven_segment_capture_seg7_to_hex.sv
// Combinational decoder: one active-low seven-segment pattern to a nibble.
// Ports:
//   seg[6:0]     active-low {g,f,e,d,c,b,a}
//   nibble[3:0]  decoded value, 0 when the pattern is not recognised
//   illegal      1 when the pattern is not in the table (blank included)
module seg7_to_hex
  import seven_segment_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       illegal
);

  always_comb begin
    nibble  = 4'h0;
    illegal = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_PATTERN[i]) begin
        nibble  = 4'(i);
        illegal = 1'b0;
      end
    end
    if (seg == SEG_ALT_9) begin
      nibble  = 4'h9;
      illegal = 1'b0;
    end
    if (seg == SEG_ALT_A) begin
      nibble  = 4'hA;
      illegal = 1'b0;
    end
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Seven-segment readback monitor: samples the display buses, waits until
// they have been unchanged for STABLE_CYCLES edges, decodes them into a
// 16-bit hex word and offers it on a valid/ready interface.
// Ports:
//   clk_clk                        rising-edge clock
//   reset_reset_n                  asynchronous active-low reset
//   seven_segment_display_0..3     digit patterns, digit 0 = LSB nibble
//   seven_segment_display_4..7     (SEG_UPPER_CHECK_EN only) upper digits
//   bus                            word output interface (master side)
//   fsm_state                      current handshake state, for observation
// Parameters: STABLE_CYCLES (>=1), DROP_W.
// Configuration macro: SEG_UPPER_CHECK_EN.
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int DROP_W        = 8
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  input  logic [6:0]                  seven_segment_display_0,
  input  logic [6:0]                  seven_segment_display_1,
  input  logic [6:0]                  seven_segment_display_2,
  input  logic [6:0]                  seven_segment_display_3,
`ifdef SEG_UPPER_CHECK_EN
  input  logic [6:0]                  seven_segment_display_4,
  input  logic [6:0]                  seven_segment_display_5,
  input  logic [6:0]                  seven_segment_display_6,
  input  logic [6:0]                  seven_segment_display_7,
`endif
  seven_segment_capture_if.master     bus,
  output state_t                      fsm_state
);

  localparam int SEG_W = NUM_DIGITS * 7;
  localparam int CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(STABLE_CYCLES - 1);

  logic [SEG_W-1:0] seg_in;
  logic [SEG_W-1:0] seg_q;
  logic [CNT_W-1:0] cnt;
  logic             same;
  logic             capture;
  logic             handshake;
  logic             overwrite;

  state_t state_q, state_d;

  logic [3:0]        nibble [4];
  logic [3:0]        illegal;
  logic [15:0]       data_q;
  logic [3:0]        mask_q;
  logic              overrun_q;
  logic [DROP_W-1:0] drop_q;

`ifdef SEG_UPPER_CHECK_EN
  assign seg_in = {seven_segment_display_7, seven_segment_display_6,
                   seven_segment_display_5, seven_segment_display_4,
                   seven_segment_display_3, seven_segment_display_2,
                   seven_segment_display_1, seven_segment_display_0};
`else
  assign seg_in = {seven_segment_display_3, seven_segment_display_2,
                   seven_segment_display_1, seven_segment_display_0};
`endif

  // Capture fires once, on the edge the counter reaches STABLE_CYCLES; the
  // counter then saturates so an unchanged pattern is never recaptured.
  assign same    = (seg_in == seg_q);
  assign capture = same && (cnt == CNT_ARM);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      seg_q <= {NUM_DIGITS{SEG_BLANK}};
      cnt   <= '0;
    end else begin
      seg_q <= seg_in;
      if (!same) begin
        cnt <= '0;
      end else if (cnt != CNT_SAT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // At a capture edge seg_q already equals the input, so decoding the
  // registered copy is equivalent and keeps the decoders off the pins.
  for (genvar g = 0; g < 4; g++) begin : g_dec
    seg7_to_hex u_dec (
      .seg     (seg_q[g*7 +: 7]),
      .nibble  (nibble[g]),
      .illegal (illegal[g])
    );
  end

  assign handshake = (state_q == S_OFFER) && bus.data_ready;
  assign overwrite = capture && (state_q == S_OFFER) && !bus.data_ready;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= S_TRACK;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TRACK: if (capture) state_d = S_OFFER;
      S_OFFER: if (handshake && !capture) state_d = S_TRACK;
      default: state_d = S_TRACK;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      data_q    <= '0;
      mask_q    <= '0;
      overrun_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      overrun_q <= overwrite;
      if (capture) begin
        data_q <= {nibble[3], nibble[2], nibble[1], nibble[0]};
        mask_q <= illegal;
      end
      if (overwrite && (drop_q != {DROP_W{1'b1}})) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

`ifdef SEG_UPPER_CHECK_EN
  logic upper_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      upper_q <= 1'b0;
    end else if (capture) begin
      upper_q <= (seg_q[SEG_W-1:28] != {4{SEG_BLANK}});
    end
  end

  assign bus.upper_nonblank = upper_q;
`endif

  assign bus.data_out   = data_q;
  assign bus.error_mask = mask_q;
  assign bus.data_valid = (state_q == S_OFFER);
  assign bus.overrun    = overrun_q;
  assign bus.drop_count = drop_q;
  assign fsm_state      = state_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture: capture latency, hold under
// backpressure, glitch re-arm, illegal patterns, overrun and simultaneous
// capture/accept, asynchronous reset mid-offer.
// Configuration macro: SEG_UPPER_CHECK_EN (adds the upper-digit step).
module tb_seven_segment_capture;
  import seven_segment_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [6:0] d0, d1, d2, d3;
`ifdef SEG_UPPER_CHECK_EN
  logic [6:0] d4, d5, d6, d7;
`endif
  state_t     fsm_state;

  int checks   = 0;
  int failures = 0;

  seven_segment_capture_if #(.DROP_W(8)) bus ();

  seven_segment_capture #(.STABLE_CYCLES(4), .DROP_W(8)) dut (
    .clk_clk                 (clk),
    .reset_reset_n           (rst_n),
    .seven_segment_display_0 (d0),
    .seven_segment_display_1 (d1),
    .seven_segment_display_2 (d2),
    .seven_segment_display_3 (d3),
`ifdef SEG_UPPER_CHECK_EN
    .seven_segment_display_4 (d4),
    .seven_segment_display_5 (d5),
    .seven_segment_display_6 (d6),
    .seven_segment_display_7 (d7),
`endif
    .bus                     (bus),
    .fsm_state               (fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_digits(input logic [6:0] a0, input logic [6:0] a1,
                            input logic [6:0] a2, input logic [6:0] a3);
    d0 = a0;
    d1 = a1;
    d2 = a2;
    d3 = a3;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.data_ready = 1'b0;
    set_digits(7'h24, 7'h30, 7'h40, 7'h79);
`ifdef SEG_UPPER_CHECK_EN
    d4 = 7'h7F; d5 = 7'h7F; d6 = 7'h7F; d7 = 7'h7F;
`endif

    // Reset state
    #12;
    check("rst_valid", 32'(bus.data_valid), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'h0);
    check("rst_mask", 32'(bus.error_mask), 32'h0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_drop", 32'(bus.drop_count), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(S_TRACK));
    @(negedge clk);
    rst_n = 1'b1;

    // First word: E0 samples it, capture at E0+4
    step();
    check("lat_e0_valid", 32'(bus.data_valid), 32'd0);
    steps(3);
    check("lat_e3_valid", 32'(bus.data_valid), 32'd0);
    step();
    check("lat_e4_valid", 32'(bus.data_valid), 32'd1);
    check("w1_data", 32'(bus.data_out), 32'h1032);
    check("w1_mask", 32'(bus.error_mask), 32'h0);
    check("w1_state", 32'(fsm_state), 32'(S_OFFER));

    // Backpressure: word held for 20 cycles
    steps(20);
    check("hold_valid", 32'(bus.data_valid), 32'd1);
    check("hold_data", 32'(bus.data_out), 32'h1032);
    check("hold_overrun", 32'(bus.overrun), 32'd0);
    bus.data_ready = 1'b1;
    step();
    check("accept_valid", 32'(bus.data_valid), 32'd0);
    steps(6);
    check("no_recapture", 32'(bus.data_valid), 32'd0);
    bus.data_ready = 1'b0;

    // Glitch on d2 re-arms; capture 4 edges after restore
    d2 = 7'h00;
    step();
    d2 = 7'h40;
    step();
    steps(3);
    check("glitch_early", 32'(bus.data_valid), 32'd0);
    step();
    check("glitch_valid", 32'(bus.data_valid), 32'd1);
    check("glitch_data", 32'(bus.data_out), 32'h1032);
    bus.data_ready = 1'b1;
    step();
    check("glitch_accept", 32'(bus.data_valid), 32'd0);

    // Illegal patterns: blank on d1, 7'h55 on d3
    set_digits(7'h24, 7'h7F, 7'h40, 7'h55);
    steps(4);
    check("ill_early", 32'(bus.data_valid), 32'd0);
    step();
    bus.data_ready = 1'b0;
    check("ill_valid", 32'(bus.data_valid), 32'd1);
    check("ill_data", 32'(bus.data_out), 32'h0002);
    check("ill_mask", 32'(bus.error_mask), 32'b1010);

    // Overrun: word 0002 still pending, new word 6745 captured
    set_digits(7'h12, 7'h19, 7'h78, 7'h02);
    steps(5);
    check("ovr_pulse", 32'(bus.overrun), 32'd1);
    check("ovr_drop", 32'(bus.drop_count), 32'd1);
    check("ovr_data", 32'(bus.data_out), 32'h6745);
    check("ovr_mask", 32'(bus.error_mask), 32'h0);
    check("ovr_valid", 32'(bus.data_valid), 32'd1);
    step();
    check("ovr_pulse_end", 32'(bus.overrun), 32'd0);
    check("ovr_drop_hold", 32'(bus.drop_count), 32'd1);

    // Capture with ready on the same edge: alternates for 9 and A
    set_digits(7'h00, 7'h10, 7'h18, 7'h20);
    steps(4);
    check("sim_pre_data", 32'(bus.data_out), 32'h6745);
    bus.data_ready = 1'b1;
    step();
    check("sim_overrun", 32'(bus.overrun), 32'd0);
    check("sim_drop", 32'(bus.drop_count), 32'd1);
    check("sim_valid", 32'(bus.data_valid), 32'd1);
    check("sim_data", 32'(bus.data_out), 32'hA998);
    step();
    check("sim_accept", 32'(bus.data_valid), 32'd0);
    bus.data_ready = 1'b0;

    // Letters b..E
    set_digits(7'h03, 7'h46, 7'h21, 7'h06);
`ifdef SEG_UPPER_CHECK_EN
    d5 = 7'h40;
`endif
    steps(5);
    check("hex_valid", 32'(bus.data_valid), 32'd1);
    check("hex_data", 32'(bus.data_out), 32'hEDCB);
    check("hex_mask", 32'(bus.error_mask), 32'h0);
`ifdef SEG_UPPER_CHECK_EN
    check("upper_nonblank", 32'(bus.upper_nonblank), 32'd1);
`endif

    // Asynchronous reset mid-offer
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.data_valid), 32'd0);
    check("arst_data", 32'(bus.data_out), 32'h0);
    check("arst_drop", 32'(bus.drop_count), 32'd0);
    check("arst_mask", 32'(bus.error_mask), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    steps(2);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
